// File: rtl/imem_loadable.sv
// Loadable instruction memory: streaming word-by-word load port plus a
// 1-cycle-latency fetch port that flags misaligned or out-of-range requests.
module imem_loadable #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH      = 64,
  parameter int unsigned     AW         = $clog2(DEPTH),
  parameter bit              BOOT_LOAD  = 1'b1,
  parameter logic [XLEN-1:0] FAULT_WORD = 'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic [XLEN-1:0] load_data,
  input  logic            load_last,
  output logic            load_ready,
  output logic [AW:0]     load_count,
  input  logic            fetch_req,
  input  logic [31:0]     fetch_addr,
  output logic            fetch_ready,
  output logic            rdata_valid,
  output logic [XLEN-1:0] rdata,
  output logic            fetch_fault
);

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  localparam state_e      RESET_STATE = BOOT_LOAD ? ST_LOAD : ST_RUN;
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [AW:0]   COUNT_MAX = (AW+1)'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;

  logic            load_acc;
  logic            fetch_acc;
  logic            fetch_bad;
  logic [AW-1:0]   fetch_idx;

  assign load_acc  = (state_q == ST_LOAD) && load_valid;
  assign fetch_acc = (state_q == ST_RUN) && fetch_req;
  assign fetch_idx = fetch_addr[AW+1:2];
  // Any set bit above the word-index field means the address lies past 4*DEPTH.
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:AW+2] != '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    valid_d = fetch_acc;
    rdata_d = rdata_q;
    fault_d = fault_q;

    case (state_q)
      ST_LOAD: begin
        if (load_valid) begin
          if (ptr_q != PTR_LAST) ptr_d = ptr_q + 1'b1;
          if (count_q != COUNT_MAX) count_d = count_q + 1'b1;
          if (load_last || (ptr_q == PTR_LAST)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      default: state_d = RESET_STATE;
    endcase

    if (fetch_acc) begin
      fault_d = fetch_bad;
      rdata_d = fetch_bad ? FAULT_WORD : mem[fetch_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
      ptr_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Storage is deliberately outside the reset domain so reset keeps loaded words.
  always_ff @(posedge clk) begin
    if (load_acc) mem[ptr_q] <= load_data;
  end

  assign load_ready  = (state_q == ST_LOAD);
  assign fetch_ready = (state_q == ST_RUN);
  assign load_count  = count_q;
  assign rdata_valid = valid_q;
  assign rdata       = rdata_q;
  assign fetch_fault = fault_q;

endmodule
